// File: rtl/cntr_read_arb.sv
// cntr_read_arb: round-robin read arbiter for the three counter outputs.
// Drives SELECT_3 and waits SETTLE cycles after arbitration. It then
// captures the selected counter value and returns it with a one-cycle
// RD_VALID pulse and a one-hot GNT.
module cntr_read_arb #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [2*NREQ-1:0] REQ_CH,
  input  logic [WIDTH-1:0]  CNTR_IN1,
  input  logic [WIDTH-1:0]  CNTR_IN2,
  input  logic [WIDTH-1:0]  CNTR_IN3,
  output logic              SELECT_3,
  output logic [NREQ-1:0]   GNT,
  output logic [WIDTH-1:0]  RD_DATA,
  output logic              RD_VALID,
  output logic              BUSY
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [1:0]        ch_q, ch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sel3_q, sel3_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [1:0]        win_ch;
  int unsigned       arb_idx;

  // Round-robin search starting at ptr_q, wrapping modulo NREQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    arb_idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      arb_idx = 32'(ptr_q) + i;
      if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
      if (!win_found && REQ[IW'(arb_idx)]) begin
        win_found = 1'b1;
        win_idx   = IW'(arb_idx);
      end
    end
    win_ch = REQ_CH[{win_idx, 1'b0} +: 2];
  end

  // State and output registers, asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      ch_q       <= '0;
      cnt_q      <= '0;
      sel3_q     <= 1'b1;
      gnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      sel3_q     <= sel3_d;
      gnt_q      <= gnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state: arbitrate in IDLE, count down the settle time in WAIT
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          win_d   = win_idx;
          ch_d    = win_ch;
          cnt_d   = CW'(SETTLE);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs: mux select at arbitration, capture and pulse at settle end
  always_comb begin
    sel3_d     = sel3_q;
    gnt_d      = '0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          if (win_ch == 2'd3)      sel3_d = 1'b0;
          else if (win_ch == 2'd2) sel3_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          case (ch_q)
            2'd0:    rd_data_d = CNTR_IN1;
            2'd1:    rd_data_d = CNTR_IN2;
            default: rd_data_d = CNTR_IN3;
          endcase
          rd_valid_d = 1'b1;
          gnt_d      = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
          busy_d     = 1'b0;
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign SELECT_3 = sel3_q;
  assign GNT      = gnt_q;
  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;
  assign BUSY     = busy_q;

endmodule

// File: doc/cntr_read_arb.md
Name: cntr_read_arb

Overview:
- Shares read access to the three counter outputs of the counter/clock-divider block between NREQ requesters.
- Round-robin arbitration; one read at a time.
- Drives the counter block's SELECT_3 mux control.
- Waits a programmable settle time after any select change, then captures the selected counter value and returns it with a valid pulse and a one-hot grant.
- Sits between software/debug requesters and the counter block.

Parameters:
- NREQ, 3, number of requesters (2..8).
- WIDTH, 3, counter width; matches the counter block's `WIDTH.
- SETTLE, 2, cycles waited after select setup before capture (0..15).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- REQ  input  NREQ  per-requester read request, level, held until GNT.
- REQ_CH  input  2*NREQ  channel per requester, bits [2i+1:2i]. Codes:
  - 0: CNTR_OUT1
  - 1: CNTR_OUT2
  - 2: CNTR_OUT3 in counter mode
  - 3: CNTR_OUT3 in bypass mode
- CNTR_IN1  input  WIDTH  from counter block CNTR_OUT1.
- CNTR_IN2  input  WIDTH  from counter block CNTR_OUT2.
- CNTR_IN3  input  WIDTH  from counter block CNTR_OUT3.
- SELECT_3  output  1  to counter block. 1 = counter 3, 0 = BYPASS.
- GNT  output  NREQ  one-hot, 1-cycle pulse marking the served requester.
- RD_DATA  output  WIDTH  captured counter value, held until next capture.
- RD_VALID  output  1  1-cycle pulse, coincident with GNT.
- BUSY  output  1  high while a transaction is in flight (state WAIT).

Interface decision (fixed): one clock, CLK; reset RST is asynchronous and active-high.

Behaviour:
- Reset values: state IDLE, PTR=0, CNT=0, SELECT_3=1, GNT=0, RD_DATA=0, RD_VALID=0, BUSY=0.
- RST asserted mid-transaction aborts it immediately (asynchronous). No GNT/RD_VALID is issued for the aborted request.
- Two-state FSM, IDLE and WAIT. All outputs are registered.
- IDLE, REQ==0: nothing changes. GNT and RD_VALID are 0.
- IDLE, REQ!=0: winner W = first set REQ bit searching PTR, PTR+1, ... NREQ-1, 0, ... (wrap). On this edge:
  - latch W and CH=REQ_CH[W];
  - SELECT_3 <= 0 if CH==3, 1 if CH==2, unchanged if CH is 0 or 1;
  - CNT <= SETTLE; BUSY <= 1; state <= WAIT.
- WAIT, CNT!=0: CNT <= CNT-1.
- WAIT, CNT==0 (capture edge):
  - RD_DATA <= CNTR_IN1 (CH 0), CNTR_IN2 (CH 1), or CNTR_IN3 (CH 2/3);
  - RD_VALID <= 1; GNT <= one-hot(W); BUSY <= 0;
  - PTR <= W+1 mod NREQ; state <= IDLE.
- Latency: arbitration at edge k gives RD_VALID/GNT high for the cycle following edge k+SETTLE+1. SETTLE=0 gives capture on edge k+1.
- Throughput: next arbitration no earlier than edge k+SETTLE+2, i.e. one read per SETTLE+2 cycles.
- REQ/REQ_CH are sampled only at the arbitration edge. Changes during WAIT are ignored.
- A requester dropping REQ before arbitration is simply not considered. Dropping it during WAIT does not cancel; the result is still delivered.
- Requesters must deassert REQ in the cycle GNT is seen. If REQ is still high in the GNT cycle, arbitration at the next edge treats it as a new request (rotated priority still applies).
- SELECT_3 persists between transactions. It is not restored after a bypass read.
- RD_DATA is a snapshot of the live counter at the capture edge, not at the arbitration edge.
- Counter wrap-around is transparent: values are copied modulo 2^WIDTH, with no arithmetic in this block.
- REQ_CH of non-requesting channels is don't-care.

Test Plan:
1. Reset, then REQ=3'b001, REQ_CH[1:0]=0, CNTR_IN1 incrementing, SETTLE=2. Arbitrate at edge k:
   - RD_VALID=1 and GNT=3'b001 after edge k+3;
   - RD_DATA equals CNTR_IN1 sampled at edge k+3;
   - BUSY high for cycles after k..k+2.
2. REQ=3'b111 held continuously, all CH=1. GNT order is 001, 010, 100, 001, with grants spaced exactly 4 cycles apart.
3. Requester 0 CH=3 with CNTR_IN3 driven to 5:
   - SELECT_3 goes 1->0 at the arbitration edge; RD_DATA=5.
   - Requester 0 then CH=2: SELECT_3 returns to 1.
   - A following CH=0 read leaves SELECT_3=1.
4. SETTLE=0 build, single request. RD_VALID one cycle after the arbitration edge; back-to-back requests served every 2 cycles.
5. Assert RST for 1 cycle during WAIT:
   - SELECT_3=1, BUSY=0, RD_DATA=0 immediately;
   - no GNT/RD_VALID;
   - PTR=0, so a subsequent REQ=3'b110 grants requester 1 first.
6. CNTR_IN2 wraps 7->0 during WAIT. RD_DATA is 0 if the wrap precedes the capture edge. REQ_CH changed during WAIT does not alter the captured source.
